// File: rtl/dm_cmd_dispatcher.sv
// dm_cmd_dispatcher
// Turns decoded UART message words into column-write transactions for the
// dot-matrix controller. A message is decoded one cycle after capture and then
// issues a single column write, a full-matrix clear/fill sweep or an enable
// update. A 1-deep pending buffer absorbs one message that arrives while busy.
// Rejected commands and dropped messages are counted.
//
// Ports:
//   clk          clock (UART rx domain)
//   reset        synchronous, active-high reset
//   msg          message word: [31:24] opcode, [23:16] column, [15:8] row, [7:0] arg
//   msg_ready    one-cycle valid pulse for msg
//   dm_write     one-cycle column write strobe
//   dm_col_addr  column address, holds its value between strobes
//   dm_row_in    row data, holds its value between strobes
//   dm_enable    display enable level
//   busy         FSM not idle or a message is waiting in the pending buffer
//   cmd_err      one-cycle pulse on a rejected command
//   overrun      one-cycle pulse on a dropped message
//   err_cnt      saturating count of rejects plus drops
module dm_cmd_dispatcher #(
  parameter int unsigned NCOLS      = 5,
  parameter int unsigned COLW       = 5,
  parameter int unsigned ROWW       = 7,
  parameter bit          ENABLE_RST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     msg,
  input  logic            msg_ready,
  output logic            dm_write,
  output logic [COLW-1:0] dm_col_addr,
  output logic [ROWW-1:0] dm_row_in,
  output logic            dm_enable,
  output logic            busy,
  output logic            cmd_err,
  output logic            overrun,
  output logic [7:0]      err_cnt
);

  localparam logic [7:0] OpWriteCol = 8'h01;
  localparam logic [7:0] OpClear    = 8'h02;
  localparam logic [7:0] OpFill     = 8'h03;
  localparam logic [7:0] OpEnable   = 8'h04;

  typedef enum logic [1:0] {StIdle, StDecode, StWrite, StSweep} state_e;

  state_e          r_state, w_state_nxt;
  logic [31:0]     r_cmd, w_cmd_nxt;
  logic [31:0]     r_pend, w_pend_nxt;
  logic            r_pend_vld, w_pend_vld_nxt;
  logic [COLW-1:0] r_col, w_col_nxt;
  logic [ROWW-1:0] r_row, w_row_nxt;
  logic            r_enable, w_enable_nxt;
  logic            r_cmd_err, w_cmd_err_nxt;
  logic            r_overrun, w_overrun_nxt;
  logic [7:0]      r_err_cnt, w_err_cnt_nxt;

  logic [7:0]      w_opcode;
  logic [7:0]      w_col_field;
  logic            w_col_ok;
  logic [1:0]      w_err_inc;
  logic [8:0]      w_err_sum;
  logic            w_unused_cmd;

  assign w_opcode    = r_cmd[31:24];
  assign w_col_field = r_cmd[23:16];
  // Comparing the full 8-bit field also rejects any bit set above COLW.
  assign w_col_ok    = 32'(w_col_field) < NCOLS;
  // Argument bits other than bit 0 carry no meaning for any opcode.
  assign w_unused_cmd = ^r_cmd;

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_nxt      = r_cmd;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_enable_nxt   = r_enable;
    w_cmd_err_nxt  = 1'b0;
    w_overrun_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (r_pend_vld) begin
          w_cmd_nxt   = r_pend;
          w_state_nxt = StDecode;
          // A message arriving while pending drains refills the buffer.
          if (msg_ready) begin
            w_pend_nxt = msg;
          end else begin
            w_pend_vld_nxt = 1'b0;
          end
        end else if (msg_ready) begin
          w_cmd_nxt   = msg;
          w_state_nxt = StDecode;
        end
      end

      StDecode: begin
        w_state_nxt = StIdle;
        case (w_opcode)
          OpWriteCol: begin
            if (w_col_ok) begin
              w_state_nxt = StWrite;
              w_col_nxt   = w_col_field[COLW-1:0];
              w_row_nxt   = r_cmd[8 +: ROWW];
            end else begin
              w_cmd_err_nxt = 1'b1;
            end
          end
          OpClear: begin
            w_state_nxt = StSweep;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
          end
          OpFill: begin
            w_state_nxt = StSweep;
            w_col_nxt   = '0;
            w_row_nxt   = r_cmd[8 +: ROWW];
          end
          OpEnable: begin
            w_enable_nxt = r_cmd[0];
          end
          default: begin
            w_cmd_err_nxt = 1'b1;
          end
        endcase
      end

      StWrite: begin
        w_state_nxt = StIdle;
      end

      StSweep: begin
        // The column address register doubles as the sweep index.
        if (r_col == COLW'(NCOLS - 1)) begin
          w_state_nxt = StIdle;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
    endcase

    if ((r_state != StIdle) && msg_ready) begin
      if (!r_pend_vld) begin
        w_pend_nxt     = msg;
        w_pend_vld_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  assign w_err_inc = {1'b0, w_cmd_err_nxt} + {1'b0, w_overrun_nxt};
  assign w_err_sum = {1'b0, r_err_cnt} + {7'b0, w_err_inc};
  assign w_err_cnt_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_enable   <= ENABLE_RST;
      r_cmd_err  <= 1'b0;
      r_overrun  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_enable   <= w_enable_nxt;
      r_cmd_err  <= w_cmd_err_nxt;
      r_overrun  <= w_overrun_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign dm_write    = (r_state == StWrite) || (r_state == StSweep);
  assign dm_col_addr = r_col;
  assign dm_row_in   = r_row;
  assign dm_enable   = r_enable;
  assign busy        = (r_state != StIdle) || r_pend_vld;
  assign cmd_err     = r_cmd_err;
  assign overrun     = r_overrun;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_dm_cmd_dispatcher.sv
// Bench for dm_cmd_dispatcher: a write scoreboard fed as commands are driven,
// a table of single-command vectors, and hand sequences for the timing-sensitive
// cases (latency, pending/overrun, reset mid-sweep, counter saturation).
module tb_dm_cmd_dispatcher;

  logic        clk;
  logic        reset;
  logic [31:0] msg;
  logic        msg_ready;
  logic        dm_write;
  logic [4:0]  dm_col_addr;
  logic [6:0]  dm_row_in;
  logic        dm_enable;
  logic        busy;
  logic        cmd_err;
  logic        overrun;
  logic [7:0]  err_cnt;

  dm_cmd_dispatcher #(
    .NCOLS     (5),
    .COLW      (5),
    .ROWW      (7),
    .ENABLE_RST(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .msg        (msg),
    .msg_ready  (msg_ready),
    .dm_write   (dm_write),
    .dm_col_addr(dm_col_addr),
    .dm_row_in  (dm_row_in),
    .dm_enable  (dm_enable),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] col;
    logic [6:0] row;
  } wr_t;

  typedef struct {
    logic [31:0] msg;
    int          n_wr;
    logic [4:0]  col;
    logic [6:0]  row;
    logic        err;
    logic        en;
  } vec_t;

  wr_t  exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cmd_err = 0;
  int   n_overrun = 0;
  int   exp_err = 0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t w;
    if (cmd_err === 1'b1) n_cmd_err++;
    if (overrun === 1'b1) n_overrun++;
    if (dm_write === 1'b1) begin
      chk("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("write_col", {27'b0, dm_col_addr}, {27'b0, w.col});
        chk("write_row", {25'b0, dm_row_in}, {25'b0, w.row});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] m);
    msg       = m;
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    msg       = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
    @(negedge clk);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  initial begin
    int e0;
    vecs[0] = '{32'h03_00_7F_00, 5, 5'd0, 7'h7F, 1'b0, 1'b1};
    vecs[1] = '{32'h02_00_7F_00, 5, 5'd0, 7'h00, 1'b0, 1'b1};
    vecs[2] = '{32'h01_05_12_00, 0, 5'd0, 7'h00, 1'b1, 1'b1};
    vecs[3] = '{32'h09_00_00_00, 0, 5'd0, 7'h00, 1'b1, 1'b1};
    vecs[4] = '{32'h01_00_2A_00, 1, 5'd0, 7'h2A, 1'b0, 1'b1};
    vecs[5] = '{32'h01_04_15_00, 1, 5'd4, 7'h15, 1'b0, 1'b1};
    vecs[6] = '{32'h01_24_15_00, 0, 5'd0, 7'h00, 1'b1, 1'b1};
    vecs[7] = '{32'h00_00_00_00, 0, 5'd0, 7'h00, 1'b1, 1'b1};
    vecs[8] = '{32'h04_00_00_00, 0, 5'd0, 7'h00, 1'b0, 1'b0};
    vecs[9] = '{32'h04_00_00_01, 0, 5'd0, 7'h00, 1'b0, 1'b1};

    reset = 1'b1;
    msg = '0;
    msg_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write", {31'b0, dm_write}, 32'd0);
    chk("rst_col", {27'b0, dm_col_addr}, 32'd0);
    chk("rst_row", {25'b0, dm_row_in}, 32'd0);
    chk("rst_enable", {31'b0, dm_enable}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);

    // Single WRITE_COL: strobe exactly two cycles after the message.
    tick();
    exp_q.push_back('{5'd3, 7'h55});
    send(32'h01_03_55_00);
    @(negedge clk);
    chk("t1_n1_write", {31'b0, dm_write}, 32'd0);
    chk("t1_n1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_n2_write", {31'b0, dm_write}, 32'd1);
    chk("t1_n2_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_n3_write", {31'b0, dm_write}, 32'd0);
    chk("t1_n3_busy", {31'b0, busy}, 32'd0);
    chk("t1_hold_col", {27'b0, dm_col_addr}, 32'd3);
    chk("t1_hold_row", {25'b0, dm_row_in}, 32'h55);
    chk("t1_err_cnt", {24'b0, err_cnt}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].n_wr == 1) exp_q.push_back('{vecs[i].col, vecs[i].row});
      else for (int c = 0; c < vecs[i].n_wr; c++) exp_q.push_back('{5'(c), vecs[i].row});
      e0 = n_cmd_err;
      tick();
      send(vecs[i].msg);
      wait_idle();
      if (vecs[i].err) exp_err = sat_inc(exp_err);
      chk($sformatf("v%0d_writes_left", i), 32'(exp_q.size()), 32'd0);
      chk($sformatf("v%0d_cmd_err", i), 32'(n_cmd_err - e0), {31'b0, vecs[i].err});
      chk($sformatf("v%0d_enable", i), {31'b0, dm_enable}, {31'b0, vecs[i].en});
      chk($sformatf("v%0d_err_cnt", i), {24'b0, err_cnt}, 32'(exp_err));
    end

    // FILL, WRITE_COL into pending, third message dropped while pending is full.
    for (int c = 0; c < 5; c++) exp_q.push_back('{5'(c), 7'h2A});
    exp_q.push_back('{5'd1, 7'h33});
    e0 = n_overrun;
    tick();
    send(32'h03_00_2A_00);
    send(32'h01_01_33_00);
    tick();
    send(32'h01_02_44_00);
    @(negedge clk);
    chk("t4_overrun_pulse", {31'b0, overrun}, 32'd1);
    repeat (4) @(negedge clk);
    chk("t4_decode_write", {31'b0, dm_write}, 32'd0);
    chk("t4_decode_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t4_pending_write", {31'b0, dm_write}, 32'd1);
    chk("t4_pending_col", {27'b0, dm_col_addr}, 32'd1);
    wait_idle();
    exp_err = sat_inc(exp_err);
    chk("t4_overrun_count", 32'(n_overrun - e0), 32'd1);
    chk("t4_err_cnt", {24'b0, err_cnt}, 32'(exp_err));
    chk("t4_writes_left", 32'(exp_q.size()), 32'd0);

    // ENABLE latency, then reset in the middle of a sweep.
    tick();
    send(32'h04_00_00_00);
    @(negedge clk);
    chk("t5_en_n1", {31'b0, dm_enable}, 32'd1);
    @(negedge clk);
    chk("t5_en_n2", {31'b0, dm_enable}, 32'd0);
    for (int c = 0; c < 5; c++) exp_q.push_back('{5'(c), 7'h11});
    tick();
    send(32'h03_00_11_00);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_write", {31'b0, dm_write}, 32'd0);
    chk("t5_rst_enable", {31'b0, dm_enable}, 32'd1);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    exp_err = 0;
    repeat (6) @(negedge clk);

    // Saturation of the error counter.
    e0 = n_cmd_err;
    for (int i = 0; i < 260; i++) begin
      send(32'hFF_00_00_00);
      wait_idle();
      exp_err = sat_inc(exp_err);
      chk($sformatf("t6_err_cnt_%0d", i), {24'b0, err_cnt}, 32'(exp_err));
    end
    chk("t6_cmd_err_pulses", 32'(n_cmd_err - e0), 32'd260);
    chk("t6_err_cnt_final", {24'b0, err_cnt}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
